fifo_sync: RTL and testbench

Single-clock, parametrised FIFO. It is the synchronous successor to the dual-clock FIFO, generalised in data width, depth and near-full/near-empty thresholds. It adds sticky overflow/underflow error flags. Used for buffering between same-clock blocks (bus bridges, UART/VGA data paths) where no clock-domain crossing is needed.

---
 rtl/fifo_sync.sv | 136 +++++++++++++
 tb/tb_fifo_sync.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock parametrised FIFO with sticky overflow/underflow flags
//
// Optional build macro: FIFO_SYNC_FWFT_EN (first-word-fall-through read port).
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   en_w, data_w  write request / write data
//   full_w        FIFO holds 2^ADDR_BITS entries
//   near_full_w   space_count <= NEAR_FULL_SPACE
//   space_count   free entries, 0..2^ADDR_BITS
//   en_r          read request
//   data_r        read data (registered, or head entry in FWFT builds)
//   empty_r       FIFO holds 0 entries
//   near_empty_r  data_count <= NEAR_EMPTY_COUNT
//   data_count    stored entries, 0..2^ADDR_BITS
//   overflow      sticky: write requested while full
//   underflow     sticky: read requested while empty
//   err_clr       clears overflow/underflow (a coincident set wins)

module fifo_sync #(
    parameter int unsigned DATA_BITS        = 32,
    parameter int unsigned ADDR_BITS        = 4,
    parameter int unsigned NEAR_FULL_SPACE  = 2,
    parameter int unsigned NEAR_EMPTY_COUNT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_w,
    input  logic [DATA_BITS-1:0] data_w,
    output logic                 full_w,
    output logic                 near_full_w,
    output logic [ADDR_BITS:0]   space_count,
    input  logic                 en_r,
    output logic [DATA_BITS-1:0] data_r,
    output logic                 empty_r,
    output logic                 near_empty_r,
    output logic [ADDR_BITS:0]   data_count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 err_clr
);

    localparam int unsigned         DEPTH     = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0]  DEPTH_CNT = {1'b1, {ADDR_BITS{1'b0}}};

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;

    logic                 wr_acc;
    logic                 rd_acc;
    logic [ADDR_BITS:0]   count_next;
    logic [ADDR_BITS:0]   space_next;

    // Acceptance looks only at the registered flags, so a same-cycle pop
    // never frees room for a push into a full FIFO (and vice versa).
    assign wr_acc = en_w && !full_w;
    assign rd_acc = en_r && !empty_r;

    always_comb begin
        count_next = data_count;
        if (wr_acc && !rd_acc) begin
            count_next = data_count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_next = data_count - 1'b1;
        end
        space_next = DEPTH_CNT - count_next;
    end

    // Storage is not reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= data_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            data_count   <= '0;
            space_count  <= DEPTH_CNT;
            empty_r      <= 1'b1;
            near_empty_r <= 1'b1;
            full_w       <= 1'b0;
            near_full_w  <= (DEPTH <= NEAR_FULL_SPACE);
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            data_count   <= count_next;
            space_count  <= space_next;
            empty_r      <= (count_next == '0);
            full_w       <= (count_next == DEPTH_CNT);
            near_empty_r <= (32'(count_next) <= 32'(NEAR_EMPTY_COUNT));
            near_full_w  <= (32'(space_next) <= 32'(NEAR_FULL_SPACE));
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    // Head entry is always presented; content is meaningless while empty.
    assign data_r = mem[rd_ptr];
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= '0;
        end else if (rd_acc) begin
            data_r <= mem[rd_ptr];
        end
    end
`endif

    // Sticky error flags: a new error event takes priority over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (en_w && full_w) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (en_r && empty_r) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - directed self-checking bench for fifo_sync (standard read build)

module tb_fifo_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_w;
    logic [31:0] data_w;
    logic        full_w;
    logic        near_full_w;
    logic [4:0]  space_count;
    logic        en_r;
    logic [31:0] data_r;
    logic        empty_r;
    logic        near_empty_r;
    logic [4:0]  data_count;
    logic        overflow;
    logic        underflow;
    logic        err_clr;

    int vectors     = 0;
    int miscompares = 0;

    fifo_sync #(
        .DATA_BITS        (32),
        .ADDR_BITS        (4),
        .NEAR_FULL_SPACE  (2),
        .NEAR_EMPTY_COUNT (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_w         (en_w),
        .data_w       (data_w),
        .full_w       (full_w),
        .near_full_w  (near_full_w),
        .space_count  (space_count),
        .en_r         (en_r),
        .data_r       (data_r),
        .empty_r      (empty_r),
        .near_empty_r (near_empty_r),
        .data_count   (data_count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en_w = 1'b0; en_r = 1'b0; data_w = '0; err_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset / idle state
        check("rst_empty",      64'(empty_r),      64'd1);
        check("rst_near_empty", 64'(near_empty_r), 64'd1);
        check("rst_count",      64'(data_count),   64'd0);
        check("rst_space",      64'(space_count),  64'd16);
        check("rst_full",       64'(full_w),       64'd0);
        check("rst_near_full",  64'(near_full_w),  64'd0);
        check("rst_data_r",     64'(data_r),       64'd0);
        check("rst_overflow",   64'(overflow),     64'd0);
        check("rst_underflow",  64'(underflow),    64'd0);

        // Fill with 1001..1016
        for (int i = 0; i < 16; i++) begin
            en_w = 1'b1; data_w = 32'(1001 + i);
            step();
            check("fill_count",     64'(data_count),  64'(i + 1));
            check("fill_space",     64'(space_count), 64'(15 - i));
            check("fill_near_full", 64'(near_full_w), (i + 1 >= 14) ? 64'd1 : 64'd0);
            check("fill_full",      64'(full_w),      (i == 15) ? 64'd1 : 64'd0);
            check("fill_empty",     64'(empty_r),     64'd0);
        end
        // 17th write rejected
        data_w = 32'd1017;
        step();
        en_w = 1'b0;
        check("ovf_flag",  64'(overflow),   64'd1);
        check("ovf_count", 64'(data_count), 64'd16);
        check("ovf_full",  64'(full_w),     64'd1);

        // Drain 16
        for (int i = 0; i < 16; i++) begin
            en_r = 1'b1;
            step();
            check("drain_data",  64'(data_r),     64'(1001 + i));
            check("drain_count", 64'(data_count), 64'(15 - i));
        end
        check("drain_empty",      64'(empty_r),      64'd1);
        check("drain_near_empty", 64'(near_empty_r), 64'd1);
        check("drain_underflow0", 64'(underflow),    64'd0);
        step();
        en_r = 1'b0;
        check("udf_flag", 64'(underflow),  64'd1);
        check("udf_hold", 64'(data_r),     64'd1016);
        check("udf_count", 64'(data_count), 64'd0);

        // Clear sticky flags
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_overflow",  64'(overflow),  64'd0);
        check("clr_underflow", 64'(underflow), 64'd0);

        // Interleaved 20 writes / 20 reads crossing the pointer wrap
        for (int i = 0; i <= 20; i++) begin
            en_w   = (i < 20);
            data_w = 32'(2000 + i);
            en_r   = (i >= 1);
            step();
            if (i >= 1) begin
                check("wrap_data", 64'(data_r), 64'(2000 + i - 1));
            end
            check("wrap_count", 64'(data_count), (i < 20) ? 64'd1 : 64'd0);
        end
        en_w = 1'b0; en_r = 1'b0;
        check("wrap_underflow", 64'(underflow), 64'd0);

        // Simultaneous push/pop with 5 stored
        for (int i = 0; i < 5; i++) begin
            en_w = 1'b1; data_w = 32'(3000 + i);
            step();
        end
        data_w = 32'd3005; en_r = 1'b1;
        step();
        en_w = 1'b0;
        check("sim5_count", 64'(data_count), 64'd5);
        check("sim5_data",  64'(data_r),     64'd3000);
        for (int i = 1; i <= 5; i++) begin
            step();
            check("sim5_order", 64'(data_r), 64'(3000 + i));
        end
        en_r = 1'b0;
        check("sim5_empty", 64'(empty_r), 64'd1);

        // Simultaneous push/pop while empty: only the write lands
        en_w = 1'b1; en_r = 1'b1; data_w = 32'd4000;
        step();
        en_w = 1'b0; en_r = 1'b0;
        check("sim0_count",     64'(data_count), 64'd1);
        check("sim0_empty",     64'(empty_r),    64'd0);
        check("sim0_data_hold", 64'(data_r),     64'd3005);
        check("sim0_underflow", 64'(underflow),  64'd1);
        en_r = 1'b1;
        step();
        en_r = 1'b0;
        check("sim0_read", 64'(data_r), 64'd4000);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Simultaneous push/pop while full: only the read lands
        for (int i = 0; i < 16; i++) begin
            en_w = 1'b1; data_w = 32'(5000 + i);
            step();
        end
        data_w = 32'd5016; en_r = 1'b1;
        step();
        en_w = 1'b0; en_r = 1'b0;
        check("sim16_count",    64'(data_count), 64'd15);
        check("sim16_overflow", 64'(overflow),   64'd1);
        check("sim16_data",     64'(data_r),     64'd5000);
        check("sim16_full",     64'(full_w),     64'd0);

        // Mid-stream reset with a coincident write
        rst = 1'b1; en_w = 1'b1; data_w = 32'd6000;
        step();
        rst = 1'b0; en_w = 1'b0;
        check("mrst_empty",    64'(empty_r),     64'd1);
        check("mrst_count",    64'(data_count),  64'd0);
        check("mrst_space",    64'(space_count), 64'd16);
        check("mrst_overflow", 64'(overflow),    64'd0);
        check("mrst_data_r",   64'(data_r),      64'd0);

        // Set wins over a coincident clear
        en_r = 1'b1; err_clr = 1'b1;
        step();
        en_r = 1'b0; err_clr = 1'b0;
        check("set_wins", 64'(underflow), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
